// File: rtl/my_mux_pkg.sv
// Shared types and constants for the 4-way merge arbiter.
// Source-select encoding matches the 4-way demux so responses can be routed back.
package my_mux_pkg;
  localparam int WIDTH = 16;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;
endpackage

// File: rtl/my_and.sv
// N-input AND primitive; purely combinational.
module my_and #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  output logic         y
);
  assign y = &a;
endmodule

// File: rtl/my_not.sv
// Bitwise inverter primitive; purely combinational.
module my_not #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);
  assign y = ~a;
endmodule

// File: rtl/my_or.sv
// N-input OR primitive; purely combinational.
module my_or #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  output logic         y
);
  assign y = |a;
endmodule

// File: rtl/my_rr_pick_4.sv
// Round-robin picker over four requesters, search starting just after 'last'.
// Combinational, zero latency; no state, backpressure is handled by the caller.
module my_rr_pick_4 (
  input  logic [3:0] valid,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       any
);
  logic [1:0] nlast;
  logic [3:0] nv;
  logic [3:0] l;
  logic [3:0] g;

  my_not #(.N(2)) u_nlast (.a(last),  .y(nlast));
  my_not #(.N(4)) u_nv    (.a(valid), .y(nv));

  // One-hot decode of the previous winner, same shape as the demux select decode.
  my_and #(.N(2)) u_l0 (.a({nlast[1], nlast[0]}), .y(l[0]));
  my_and #(.N(2)) u_l1 (.a({nlast[1], last[0]}),  .y(l[1]));
  my_and #(.N(2)) u_l2 (.a({last[1],  nlast[0]}), .y(l[2]));
  my_and #(.N(2)) u_l3 (.a({last[1],  last[0]}),  .y(l[3]));

  // Source i wins if every source between the previous winner and i is idle.
  for (genvar i = 0; i < 4; i++) begin : g_src
    localparam int P1 = (i + 1) % 4;
    localparam int P2 = (i + 2) % 4;
    localparam int P3 = (i + 3) % 4;
    logic t1, t2, t3, hit;

    my_and #(.N(2)) u_t1  (.a({l[P2], nv[P3]}),                .y(t1));
    my_and #(.N(3)) u_t2  (.a({l[P1], nv[P2], nv[P3]}),        .y(t2));
    my_and #(.N(4)) u_t3  (.a({l[i],  nv[P1], nv[P2], nv[P3]}), .y(t3));
    my_or  #(.N(4)) u_hit (.a({l[P3], t1, t2, t3}),            .y(hit));
    my_and #(.N(2)) u_g   (.a({valid[i], hit}),                .y(g[i]));
  end

  my_or #(.N(2)) u_gr1 (.a({g[3], g[2]}), .y(grant[1]));
  my_or #(.N(2)) u_gr0 (.a({g[3], g[1]}), .y(grant[0]));
  my_or #(.N(4)) u_any (.a(g),            .y(any));
endmodule

// File: rtl/my_mux_4_way_arbiter.sv
// Round-robin merge of four valid/ready sources into one registered output; 1-cycle latency.
// Accepts a new word whenever the output slot is empty or draining; all readies low under backpressure.
module my_mux_4_way_arbiter
  import my_mux_pkg::*;
#(
  parameter int WIDTH = my_mux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             d_valid,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic             d_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  sel_t             grant;
  sel_t             last_grant;
  logic             any;
  logic             load_en;
  logic             xfer;
  logic [3:0]       grant_oh;
  logic [WIDTH-1:0] win_dat;

  my_rr_pick_4 u_pick (
    .valid ({d_valid, c_valid, b_valid, a_valid}),
    .last  (last_grant),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    grant_oh = 4'b0000;
    win_dat  = a_in;
    case (grant)
      SEL_A:   begin grant_oh = 4'b0001; win_dat = a_in; end
      SEL_B:   begin grant_oh = 4'b0010; win_dat = b_in; end
      SEL_C:   begin grant_oh = 4'b0100; win_dat = c_in; end
      default: begin grant_oh = 4'b1000; win_dat = d_in; end
    endcase
  end

  // out_ready only gates acceptance; out/out_sel come straight from flops.
  assign load_en = !out_valid | out_ready;
  assign xfer    = load_en & any;

  assign a_ready = xfer & grant_oh[0];
  assign b_ready = xfer & grant_oh[1];
  assign c_ready = xfer & grant_oh[2];
  assign d_ready = xfer & grant_oh[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      out_sel    <= SEL_A;
      out_valid  <= 1'b0;
      last_grant <= SEL_D;
    end else if (xfer) begin
      out        <= win_dat;
      out_sel    <= grant;
      out_valid  <= 1'b1;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_my_mux_4_way_arbiter.sv
// Directed self-checking bench for the 4-way round-robin merge arbiter.
module tb_my_mux_4_way_arbiter;
  logic        clk;
  logic        reset;
  logic [15:0] a_in, b_in, c_in, d_in;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic        a_ready, b_ready, c_ready, d_ready;
  logic [15:0] out;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int passed = 0;
  int total  = 0;

  logic [3:0] rdy;
  assign rdy = {d_ready, c_ready, b_ready, a_ready};

  my_mux_4_way_arbiter #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .d_in      (d_in),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .c_valid   (c_valid),
    .d_valid   (d_valid),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .c_ready   (c_ready),
    .d_ready   (d_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out !== 16'h0) $display("FAIL reset_out: got %h expected %h", out, 16'h0); else passed++;
    total++; if (out_sel !== 2'b00) $display("FAIL reset_sel: got %b expected %b", out_sel, 2'b00); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected %b", out_valid, 1'b0); else passed++;
    total++; if (rdy !== 4'b0000) $display("FAIL reset_ready: got %b expected %b", rdy, 4'b0000); else passed++;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    b_in = 16'h1234; b_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (rdy !== 4'b0010) $display("FAIL single_ready: got %b expected %b", rdy, 4'b0010); else passed++;
    step();
    b_valid = 1'b0;
    total++; if (out !== 16'h1234) $display("FAIL single_out: got %h expected %h", out, 16'h1234); else passed++;
    total++; if (out_sel !== 2'b01) $display("FAIL single_sel: got %b expected %b", out_sel, 2'b01); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b expected %b", out_valid, 1'b0); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_dat;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_rdy;
    pulse_reset();
    a_in = 16'd1; b_in = 16'd2; c_in = 16'd3; d_in = 16'd4;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_sel = 2'(k % 4);
      exp_dat = 16'(k % 4 + 1);
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      total++; if (rdy !== exp_rdy) $display("FAIL b2b_ready[%0d]: got %b expected %b", k, rdy, exp_rdy); else passed++;
      step();
      total++; if (out !== exp_dat || out_valid !== 1'b1) $display("FAIL b2b_out[%0d]: got %h/%b expected %h/1", k, out, out_valid, exp_dat); else passed++;
      total++; if (out_sel !== exp_sel) $display("FAIL b2b_sel[%0d]: got %b expected %b", k, out_sel, exp_sel); else passed++;
    end
  endtask

  task automatic test_backpressure();
    b_valid = 1'b0; d_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (rdy !== 4'b0000) $display("FAIL bp_ready0: got %b expected %b", rdy, 4'b0000); else passed++;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (out !== 16'd2 || out_sel !== 2'b01 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d]: got %h/%b/%b expected 0002/01/1", k, out, out_sel, out_valid); else passed++;
      total++; if (rdy !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b expected %b", k, rdy, 4'b0000); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (rdy !== 4'b0100) $display("FAIL bp_release_ready: got %b expected %b", rdy, 4'b0100); else passed++;
    step();
    total++; if (out !== 16'd3 || out_sel !== 2'b10) $display("FAIL bp_next: got %h/%b expected 0003/10", out, out_sel); else passed++;
    total++; if (rdy !== 4'b0001) $display("FAIL bp_rr_ready: got %b expected %b", rdy, 4'b0001); else passed++;
    step();
    total++; if (out !== 16'd1 || out_sel !== 2'b00) $display("FAIL bp_rr: got %h/%b expected 0001/00", out, out_sel); else passed++;
    a_valid = 1'b0; c_valid = 1'b0;
  endtask

  task automatic test_wrap();
    pulse_reset();
    c_in = 16'h0C0C; c_valid = 1'b1; out_ready = 1'b1;
    step();
    c_valid = 1'b0;
    a_in = 16'hAAAA; d_in = 16'hDDDD; a_valid = 1'b1; d_valid = 1'b1;
    #1;
    total++; if (rdy !== 4'b1000) $display("FAIL wrap_ready_d: got %b expected %b", rdy, 4'b1000); else passed++;
    step();
    total++; if (out !== 16'hDDDD || out_sel !== 2'b11) $display("FAIL wrap_d: got %h/%b expected dddd/11", out, out_sel); else passed++;
    total++; if (rdy !== 4'b0001) $display("FAIL wrap_ready_a: got %b expected %b", rdy, 4'b0001); else passed++;
    step();
    total++; if (out !== 16'hAAAA || out_sel !== 2'b00) $display("FAIL wrap_a: got %h/%b expected aaaa/00", out, out_sel); else passed++;
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b0; d_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out !== 16'h0 || out_sel !== 2'b00)
      $display("FAIL mid_async: got %b/%h/%b expected 0/0000/00", out_valid, out, out_sel); else passed++;
    reset = 1'b0;
    a_in = 16'h5555; d_in = 16'hDDDD; a_valid = 1'b1; d_valid = 1'b1;
    #1;
    total++; if (rdy !== 4'b0001) $display("FAIL mid_ready: got %b expected %b", rdy, 4'b0001); else passed++;
    step();
    total++; if (out !== 16'h5555 || out_sel !== 2'b00 || out_valid !== 1'b1)
      $display("FAIL mid_restart: got %h/%b/%b expected 5555/00/1", out, out_sel, out_valid); else passed++;
  endtask

  task automatic test_idle();
    a_valid = 1'b0; d_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (out_valid !== 1'b0 || out !== 16'h5555 || out_sel !== 2'b00)
        $display("FAIL idle[%0d]: got %b/%h/%b expected 0/5555/00", k, out_valid, out, out_sel); else passed++;
    end
    a_in = 16'hAAAA; c_in = 16'hCCCC; a_valid = 1'b1; c_valid = 1'b1;
    #1;
    total++; if (rdy !== 4'b0100) $display("FAIL idle_ready: got %b expected %b", rdy, 4'b0100); else passed++;
    step();
    total++; if (out !== 16'hCCCC || out_sel !== 2'b10 || out_valid !== 1'b1)
      $display("FAIL idle_grant: got %h/%b/%b expected cccc/10/1", out, out_sel, out_valid); else passed++;
    a_valid = 1'b0; c_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
